im_fetch_arbiter: RTL and testbench

Controller for the CPU's synchronous single-port instruction memory (64 x 32 by default). After reset it boot-loads the program from a valid/ready loader stream, then releases the CPU. During run it shares the memory port between CPU fetch and loader writes. Arbitration alternates priority so neither side starves, and the CPU is stalled whenever it loses the port.

---
 rtl/im_fetch_arbiter_if.sv | 32 +++
 rtl/im_fetch_arbiter.sv | 60 ++++++
 tb/tb_im_fetch_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/im_fetch_arbiter_if.sv
// im_fetch_arbiter_if: loader stream, CPU fetch and instruction-memory port bundle
//   master: the arbiter (drives ld_ready, fetch results, status, memory port)
//   slave : the environment (loader, CPU, memory)
interface im_fetch_arbiter_if #(parameter int AW = 6);
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic          fetch_valid;
  logic [31:0]   fetch_instr;
  logic          cpu_stall;
  logic          boot_done;
  logic          addr_err;
  logic [AW:0]   load_cnt;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  modport master (
    input  ld_valid, ld_addr, ld_data, ld_last, fetch_req, fetch_pc, mem_rdata,
    output ld_ready, fetch_valid, fetch_instr, cpu_stall, boot_done, addr_err,
           load_cnt, mem_addr, mem_we, mem_wdata
  );
  modport slave (
    output ld_valid, ld_addr, ld_data, ld_last, fetch_req, fetch_pc, mem_rdata,
    input  ld_ready, fetch_valid, fetch_instr, cpu_stall, boot_done, addr_err,
           load_cnt, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/im_fetch_arbiter.sv
// im_fetch_arbiter: boot-loads instruction memory, then arbitrates its single port between CPU fetch and loader writes
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : loader stream, CPU fetch, status (boot_done/addr_err/load_cnt) and memory port
module im_fetch_arbiter #(
  parameter int          AW  = 6,
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input logic                 Clk,
  input logic                 Reset,
  im_fetch_arbiter_if.master  bus
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t      state, state_nxt;
  logic        run, oor, ld_win, f_win, accept;
  logic        last_ld, pend, pend_oor, err;
  logic [31:0] instr_q;
  logic [AW:0] cnt;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= BOOT;
    else        state <= state_nxt;
  always_comb
    state_nxt = (state == BOOT && bus.ld_valid && bus.ld_last) ? RUN : state;
  always_comb begin
    run             = state == RUN;
    oor             = |(bus.fetch_pc >> AW);
    // on contention the side that did not win last time gets the port
    ld_win          = run & bus.ld_valid & (~bus.fetch_req | ~last_ld);
    f_win           = run & bus.fetch_req & ~ld_win;
    bus.ld_ready    = ~run | ld_win;
    accept          = bus.ld_ready & bus.ld_valid;
    bus.mem_we      = accept;
    bus.mem_addr    = f_win ? bus.fetch_pc[AW-1:0] : bus.ld_addr;
    bus.mem_wdata   = bus.ld_data;
    bus.cpu_stall   = ~run | (bus.fetch_req & ld_win);
    bus.boot_done   = run;
    bus.fetch_valid = pend;
    // read data arrives the cycle after the grant; outside that cycle the last instruction is held
    bus.fetch_instr = pend ? (pend_oor ? NOP : bus.mem_rdata) : instr_q;
    bus.addr_err    = err;
    bus.load_cnt    = cnt;
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      pend     <= 1'b0;
      pend_oor <= 1'b0;
      instr_q  <= NOP;
      err      <= 1'b0;
      cnt      <= '0;
      last_ld  <= 1'b0;
    end else begin
      pend     <= f_win;
      pend_oor <= f_win & oor;
      if (pend) instr_q <= bus.fetch_instr;
      if (f_win & oor) err <= 1'b1;
      if (accept && !(&cnt)) cnt <= cnt + 1'b1;
      if (ld_win) last_ld <= 1'b1;
      else if (f_win) last_ld <= 1'b0;
    end
endmodule

// File: tb/tb_im_fetch_arbiter.sv
// tb_im_fetch_arbiter: directed self-checking bench for im_fetch_arbiter with a synchronous memory model
module tb_im_fetch_arbiter;
  localparam int AW = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] mem [2**AW];
  always #5 clk = ~clk;
  im_fetch_arbiter_if #(.AW(AW)) bus();
  im_fetch_arbiter #(.AW(AW), .NOP(32'h0000_0000)) dut (.Clk(clk), .Reset(rst_n), .bus(bus.master));
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic lv, input logic [AW-1:0] la, input logic [31:0] ld,
                     input logic ll, input logic fr, input logic [31:0] pc);
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.ld_data   = ld;
    bus.ld_last   = ll;
    bus.fetch_req = fr;
    bus.fetch_pc  = pc;
    #1;
  endtask
  initial begin
    drv(0, 0, 0, 0, 0, 0);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 0);
    chk("rst_boot_done", 32'(bus.boot_done), 0);
    chk("rst_load_cnt", 32'(bus.load_cnt), 0);
    chk("rst_cpu_stall", 32'(bus.cpu_stall), 1);
    chk("rst_ld_ready", 32'(bus.ld_ready), 1);
    chk("rst_fetch_instr", bus.fetch_instr, 32'h0);
    chk("rst_addr_err", 32'(bus.addr_err), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv(1, AW'(i), 32'h1111_0000 + 32'(i), i == 3, 1, 0);
      chk("boot_ld_ready", 32'(bus.ld_ready), 1);
      chk("boot_mem_we", 32'(bus.mem_we), 1);
      chk("boot_mem_addr", 32'(bus.mem_addr), 32'(i));
      chk("boot_stall", 32'(bus.cpu_stall), 1);
      chk("boot_done_low", 32'(bus.boot_done), 0);
      tick;
    end
    drv(0, 0, 0, 0, 0, 0);
    chk("boot_done", 32'(bus.boot_done), 1);
    chk("boot_load_cnt", 32'(bus.load_cnt), 4);
    chk("run_stall_idle", 32'(bus.cpu_stall), 0);
    chk("run_fv_idle", 32'(bus.fetch_valid), 0);
    drv(0, 0, 0, 0, 1, 2);
    chk("fetch_stall", 32'(bus.cpu_stall), 0);
    chk("fetch_ld_ready", 32'(bus.ld_ready), 0);
    chk("fetch_mem_we", 32'(bus.mem_we), 0);
    chk("fetch_mem_addr", 32'(bus.mem_addr), 2);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk("fetch2_valid", 32'(bus.fetch_valid), 1);
    chk("fetch2_instr", bus.fetch_instr, 32'h1111_0002);
    tick;
    chk("fetch_valid_drop", 32'(bus.fetch_valid), 0);
    chk("fetch_instr_hold", bus.fetch_instr, 32'h1111_0002);
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 0, 1, 32'(i));
      if (i > 0) begin
        chk("b2b_valid", 32'(bus.fetch_valid), 1);
        chk("b2b_instr", bus.fetch_instr, 32'h1111_0000 + 32'(i - 1));
      end
      tick;
    end
    drv(0, 0, 0, 0, 0, 0);
    chk("b2b_valid_last", 32'(bus.fetch_valid), 1);
    chk("b2b_instr_last", bus.fetch_instr, 32'h1111_0003);
    tick;
    for (int i = 0; i < 6; i++) begin
      drv(1, AW'(8 + i), 32'h2222_0000 + 32'(i), 0, 1, 1);
      chk("cont_ld_ready", 32'(bus.ld_ready), 32'(i % 2 == 0));
      chk("cont_mem_we", 32'(bus.mem_we), 32'(i % 2 == 0));
      chk("cont_stall", 32'(bus.cpu_stall), 32'(i % 2 == 0));
      chk("cont_fv", 32'(bus.fetch_valid), 32'(i > 0 && i % 2 == 0));
      tick;
    end
    drv(0, 0, 0, 0, 0, 0);
    chk("cont_fv_last", 32'(bus.fetch_valid), 1);
    chk("cont_instr", bus.fetch_instr, 32'h1111_0001);
    chk("cont_load_cnt", 32'(bus.load_cnt), 7);
    tick;
    drv(1, 5, 32'hDEAD_BEEF, 0, 0, 0);
    chk("raw_we", 32'(bus.mem_we), 1);
    tick;
    drv(0, 0, 0, 0, 1, 5);
    chk("raw_stall", 32'(bus.cpu_stall), 0);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk("raw_valid", 32'(bus.fetch_valid), 1);
    chk("raw_instr", bus.fetch_instr, 32'hDEAD_BEEF);
    chk("raw_load_cnt", 32'(bus.load_cnt), 8);
    tick;
    drv(0, 0, 0, 0, 1, 64);
    chk("oor_err_before", 32'(bus.addr_err), 0);
    tick;
    drv(0, 0, 0, 0, 1, 3);
    chk("oor_valid", 32'(bus.fetch_valid), 1);
    chk("oor_instr_nop", bus.fetch_instr, 32'h0);
    chk("oor_err", 32'(bus.addr_err), 1);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk("oor_legal_instr", bus.fetch_instr, 32'h1111_0003);
    chk("oor_err_sticky", 32'(bus.addr_err), 1);
    tick;
    drv(0, 0, 0, 0, 1, 2);
    tick;
    chk("inflight_valid", 32'(bus.fetch_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_fv", 32'(bus.fetch_valid), 0);
    chk("rst_mid_boot_done", 32'(bus.boot_done), 0);
    chk("rst_mid_load_cnt", 32'(bus.load_cnt), 0);
    chk("rst_mid_addr_err", 32'(bus.addr_err), 0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv(1, AW'(i), 32'h3333_0000 + 32'(i), 0, 1, 0);
      chk("reboot_stall", 32'(bus.cpu_stall), 1);
      tick;
    end
    drv(0, 0, 0, 0, 1, 0);
    chk("partial_load_cnt", 32'(bus.load_cnt), 2);
    chk("partial_boot_done", 32'(bus.boot_done), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_boot_load_cnt", 32'(bus.load_cnt), 0);
    chk("rst_boot_done", 32'(bus.boot_done), 0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 1, 0);
      chk("boot_ignore_fv", 32'(bus.fetch_valid), 0);
      chk("boot_ignore_stall", 32'(bus.cpu_stall), 1);
      chk("boot_ignore_we", 32'(bus.mem_we), 0);
      tick;
    end
    drv(1, 0, 32'h4444_0000, 1, 1, 0);
    chk("reboot_last_we", 32'(bus.mem_we), 1);
    tick;
    drv(0, 0, 0, 0, 1, 0);
    chk("reboot_done", 32'(bus.boot_done), 1);
    chk("reboot_load_cnt", 32'(bus.load_cnt), 1);
    chk("reboot_stall_free", 32'(bus.cpu_stall), 0);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk("reboot_fv", 32'(bus.fetch_valid), 1);
    chk("reboot_instr", bus.fetch_instr, 32'h4444_0000);
    tick;
    for (int i = 0; i < 130; i++) begin
      drv(1, AW'(i), 32'(i), 0, 0, 0);
      tick;
    end
    drv(0, 0, 0, 0, 0, 0);
    chk("sat_load_cnt", 32'(bus.load_cnt), 127);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
